// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the core's EX/MEM stage.
// Accepts one load/store request, performs the array access at the accept
// edge, then presents the response after a fixed lat_p-cycle latency and
// holds it until the core acknowledges with yumi_i.
// Optional build macro: DMEM_BOUNDS_CHECK_EN (flags accesses whose address
// bits above the array are non-zero; otherwise those bits wrap).
//
// Handshake: in IDLE, yumi_o mirrors valid_i and the request is taken on
// that clock edge. In RESP, valid_o is high with stable read_data_o; the
// response retires on the edge where yumi_i is high. Requests are ignored
// outside IDLE and yumi_i is ignored outside RESP.
module dmem_ctrl #(
    parameter int addr_width_p = 10,
    parameter int lat_p        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        wen_i,
    input  logic        byte_not_word_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        yumi_i,
    output logic        yumi_o,
    output logic        valid_o,
    output logic [31:0] read_data_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int words_lp = 1 << addr_width_p;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] resp_q, resp_d;
    logic        first_q, first_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [words_lp];

    logic                    accept;
    logic                    oob;
    logic [addr_width_p-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic [31:0]             load_data;

    assign idx       = addr_i[addr_width_p+1:2];
    assign lane      = addr_i[1:0];
    assign rd_word   = mem_q[idx];
    assign rd_byte   = 8'(rd_word >> {lane, 3'b000});
    assign load_data = byte_not_word_i ? {24'h0, rd_byte} : rd_word;

    // Reset gating keeps the array untouched while reset is asserted.
    assign accept = (state_q == IDLE) && valid_i && !reset;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob   = |(addr_i >> (addr_width_p + 2));
    assign err_o = (state_q == RESP) && first_q && err_q;
`else
    logic unused_hi;
    assign unused_hi = (^addr_i[31:addr_width_p+2]) ^ err_q ^ first_q;
    assign oob   = 1'b0;
    assign err_o = 1'b0;
`endif

    assign yumi_o      = accept;
    assign valid_o     = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign read_data_o = resp_q;

    // Storage array: written at the accept edge of an in-range store.
    always_ff @(posedge clk) begin
        if (accept && wen_i && !oob) begin
            if (byte_not_word_i) begin
                mem_q[idx][{lane, 3'b000} +: 8] <= write_data_i[7:0];
            end else begin
                mem_q[idx] <= write_data_i;
            end
        end
    end

    // State, latency counter and response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= 32'h0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the response word is captured at accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        first_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'(lat_p - 1);
                    err_d = oob;
                    if (wen_i) begin
                        resp_d = 32'h0;
                    end else if (oob) begin
                        resp_d = 32'hDEADBEEF;
                    end else begin
                        resp_d = load_data;
                    end
                    if (lat_p == 1) begin
                        state_d = RESP;
                        first_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // WAIT lasts lat_p-1 cycles: leave when the count reaches 0.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    first_d = 1'b1;
                end
            end
            RESP: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with default parameters (lat_p = 2,
// addr_width_p = 10). Inputs are driven and outputs sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        wen_i;
    logic        byte_not_word_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        yumi_i;
    logic        yumi_o;
    logic        valid_o;
    logic [31:0] read_data_o;
    logic        busy_o;
    logic        err_o;

    int compared = 0;
    int mismatched = 0;

    dmem_ctrl #(.addr_width_p(10), .lat_p(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .wen_i           (wen_i),
        .byte_not_word_i (byte_not_word_i),
        .addr_i          (addr_i),
        .write_data_i    (write_data_i),
        .yumi_i          (yumi_i),
        .yumi_o          (yumi_o),
        .valid_o         (valid_o),
        .read_data_o     (read_data_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request with yumi_i held high: checks accept, WAIT, response, return to IDLE.
    task automatic txn(input string tag, input logic wen, input logic bnw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        valid_i = 1'b1; wen_i = wen; byte_not_word_i = bnw;
        addr_i = addr; write_data_i = wd; yumi_i = 1'b1;
        #1;
        chk({tag, ".yumi_o_accept"}, 32'(yumi_o), 32'd1);
        chk({tag, ".busy_o_idle"}, 32'(busy_o), 32'd0);
        @(negedge clk);                       // cycle T+1: WAIT
        valid_i = 1'b0;
        #1;
        chk({tag, ".yumi_o_wait"}, 32'(yumi_o), 32'd0);
        chk({tag, ".valid_o_wait"}, 32'(valid_o), 32'd0);
        chk({tag, ".busy_o_wait"}, 32'(busy_o), 32'd1);
        @(negedge clk);                       // cycle T+2: RESP
        chk({tag, ".valid_o_resp"}, 32'(valid_o), 32'd1);
        chk({tag, ".read_data_o"}, read_data_o, exp_data);
        chk({tag, ".err_o_resp"}, 32'(err_o), 32'(exp_err));
        @(negedge clk);                       // back in IDLE
        chk({tag, ".valid_o_done"}, 32'(valid_o), 32'd0);
        chk({tag, ".busy_o_done"}, 32'(busy_o), 32'd0);
        chk({tag, ".read_data_hold"}, read_data_o, exp_data);
        chk({tag, ".err_o_done"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; wen_i = 1'b0; byte_not_word_i = 1'b0;
        addr_i = 32'h0; write_data_i = 32'h0; yumi_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset release: idle outputs for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst.valid_o", 32'(valid_o), 32'd0);
            chk("rst.yumi_o", 32'(yumi_o), 32'd0);
            chk("rst.busy_o", 32'(busy_o), 32'd0);
            chk("rst.read_data_o", read_data_o, 32'd0);
            chk("rst.err_o", 32'(err_o), 32'd0);
        end

        // Word store / load.
        txn("st_w10", 1'b1, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0);
        txn("ld_w10", 1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);

        // Byte store into lane 3; upper write data bits must be ignored.
        txn("st_b13", 1'b1, 1'b1, 32'h13, 32'hFFFFFFAB, 32'h0, 1'b0);
        txn("ld_w10b", 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB345678, 1'b0);
        txn("ld_b13", 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000AB, 1'b0);
        txn("ld_b11", 1'b0, 1'b1, 32'h11, 32'h0, 32'h00000056, 1'b0);
        txn("ld_b10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h00000078, 1'b0);
        // Word load ignores the low address bits.
        txn("ld_w12", 1'b0, 1'b0, 32'h12, 32'h0, 32'hAB345678, 1'b0);

        // Response held while yumi_i is low and valid_i stays high.
        @(negedge clk);
        valid_i = 1'b1; wen_i = 1'b0; byte_not_word_i = 1'b0;
        addr_i = 32'h10; yumi_i = 1'b0;
        #1;
        chk("hold.yumi_o_accept", 32'(yumi_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("hold.valid_o", 32'(valid_o), 32'd1);
            chk("hold.yumi_o", 32'(yumi_o), 32'd0);
            chk("hold.read_data_o", read_data_o, 32'hAB345678);
            @(negedge clk);
        end
        yumi_i = 1'b1;
        @(negedge clk);                       // IDLE, valid_i still high
        chk("hold.busy_o_idle", 32'(busy_o), 32'd0);
        chk("hold.yumi_o_reaccept", 32'(yumi_o), 32'd1);
        @(negedge clk);
        chk("hold.busy_o_reaccepted", 32'(busy_o), 32'd1);
        valid_i = 1'b0;
        @(negedge clk);
        chk("hold.second_resp", read_data_o, 32'hAB345678);
        chk("hold.second_valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        chk("hold.second_done", 32'(busy_o), 32'd0);

        // Reset during WAIT drops the pending load.
        @(negedge clk);
        valid_i = 1'b1; wen_i = 1'b0; byte_not_word_i = 1'b1; addr_i = 32'h11;
        yumi_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        chk("rstw.busy_o_wait", 32'(busy_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw.valid_o", 32'(valid_o), 32'd0);
        chk("rstw.busy_o", 32'(busy_o), 32'd0);
        chk("rstw.read_data_o", read_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw.no_resp", 32'(valid_o), 32'd0);
        end
        txn("rstw.ld_w10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB345678, 1'b0);

        // High address bits: wrap-around by default, flagged with bounds checking.
        txn("oob.st_w0", 1'b1, 1'b0, 32'h0, 32'h11111111, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        txn("oob.st_hi", 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
        txn("oob.ld_hi", 1'b0, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b1);
        txn("oob.ld_w0", 1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0);
`else
        txn("oob.st_hi", 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("oob.ld_hi", 1'b0, 1'b0, 32'h1000, 32'h0, 32'hCAFEF00D, 1'b0);
        txn("oob.ld_w0", 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        txn("oob.ld_b_wrap", 1'b0, 1'b1, 32'h8000_0011, 32'h0, 32'h00000056, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
